// File: rtl/cam_param_if.sv
// Request/response bundle between the lookup requester (master) and cam_param (slave).
// Clock and reset stay outside the bundle as plain ports.
interface cam_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              init_start;
  logic              busy;
  logic              wr_en;
  logic              wr_del;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              lk_en;
  logic [DATA_W-1:0] lk_key;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_addr;
  logic [CNT_W-1:0]  rsp_count;

  modport master (
    output init_start, wr_en, wr_del, wr_addr, wr_data, lk_en, lk_key,
    input  busy, rsp_valid, rsp_hit, rsp_addr, rsp_count
  );

  modport slave (
    input  init_start, wr_en, wr_del, wr_addr, wr_data, lk_en, lk_key,
    output busy, rsp_valid, rsp_hit, rsp_addr, rsp_count
  );
endinterface

// File: rtl/cam_param.sv
// Parametrised CAM: DEPTH x DATA_W entries with valid bits, single-entry write/invalidate,
// an index-value init walk, and a registered lookup returning hit, lowest address and match count.
module cam_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  cam_param_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_INIT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [CNT_W-1:0]  rsp_count_q;

  logic [DEPTH-1:0]  match;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  init_sel;
  logic              rsp_hit_d;
  logic [ADDR_W-1:0] rsp_addr_d;
  logic [CNT_W-1:0]  rsp_count_d;

  // Decoding against each entry index means out-of-range addresses (non-power-of-2 DEPTH)
  // select nothing, so they are dropped without a separate range compare.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match    = '0;
    wr_sel   = '0;
    init_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i]    = valid_q[i] && (data_q[i] == bus.lk_key);
      wr_sel[i]   = (bus.wr_addr == ADDR_W'(i));
      init_sel[i] = (idx_q == ADDR_W'(i));
    end
  end

  // Lowest-index priority encode and population count of the match vector.
  always_comb begin
    rsp_addr_d  = '0;
    rsp_count_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) rsp_addr_d = ADDR_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rsp_count_d = rsp_count_d + CNT_W'(match[i]);
    end
  end

  assign rsp_hit_d = |match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      valid_q     <= '0;
      // NOTE: the data array is reset too, so a fresh CAM has defined contents, not just invalid ones.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the lookup sees pre-write contents.
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.lk_en) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_count_q <= rsp_count_d;
          end
          if (bus.wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (wr_sel[i]) begin
                if (bus.wr_del) begin
                  valid_q[i] <= 1'b0;
                end else begin
                  data_q[i]  <= bus.wr_data;
                  valid_q[i] <= 1'b1;
                end
              end
            end
          end
          if (bus.init_start) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
          end
        end
        ST_INIT: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (init_sel[i]) begin
              data_q[i]  <= DATA_W'(idx_q);
              valid_q[i] <= 1'b1;
            end
          end
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q == ST_INIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_count = rsp_count_q;

  a_hit_count: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q |-> (rsp_hit_q == (rsp_count_q != '0)));

endmodule

// File: tb/tb_cam_param.sv
// Scoreboard bench for cam_param: a driver applies directed and random requests to a
// behavioural model, and a monitor checks each registered response against the queue.
module tb_cam_param;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    int                due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  cam_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  logic [DATA_W-1:0] md [DEPTH];
  bit                mv [DEPTH];
  int                busy_left;
  exp_t              sb [$];
  exp_t              last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model_lookup(input logic [DATA_W-1:0] key);
    exp_t e;
    int   hits [$];
    for (int i = 0; i < DEPTH; i++) if (mv[i] && md[i] == key) hits.push_back(i);
    e.hit  = (hits.size() > 0);
    e.addr = (hits.size() > 0) ? ADDR_W'(hits[0]) : '0;
    e.cnt  = CNT_W'(hits.size());
    e.due  = 0;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      md[i] = '0;
      mv[i] = 1'b0;
    end
    busy_left = 0;
    sb.delete();
    last = '{hit: 1'b0, addr: '0, cnt: '0, due: 0};
  endtask

  task automatic drive_idle();
    bus.init_start = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_del     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.lk_en      = 1'b0;
    bus.lk_key     = '0;
  endtask

  // Asserted just after an edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_hit", bus.rsp_hit, 0);
    check("rst_rsp_addr", bus.rsp_addr, 0);
    check("rst_rsp_count", bus.rsp_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: apply requests, advance the model by the same edge, check busy after it.
  task automatic step(input logic ini, input logic we, input logic del,
                      input int wa, input logic [DATA_W-1:0] wd,
                      input logic le, input logic [DATA_W-1:0] key);
    exp_t e;
    bus.init_start = ini;
    bus.wr_en      = we;
    bus.wr_del     = del;
    bus.wr_addr    = ADDR_W'(wa);
    bus.wr_data    = wd;
    bus.lk_en      = le;
    bus.lk_key     = key;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (le) begin
        e     = model_lookup(key);
        e.due = cyc + 1;
        sb.push_back(e);
      end
      if (we && wa < DEPTH) begin
        if (del) begin
          mv[wa] = 1'b0;
        end else begin
          md[wa] = wd;
          mv[wa] = 1'b1;
        end
      end
      if (ini) begin
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          md[i] = DATA_W'(i);
          mv[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("busy", bus.busy, (busy_left > 0) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, '0);
  endtask

  task automatic lookup(input logic [DATA_W-1:0] key);
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, key);
  endtask

  task automatic write(input int wa, input logic [DATA_W-1:0] wd);
    step(1'b0, 1'b1, 1'b0, wa, wd, 1'b0, '0);
  endtask

  // Monitor: pops one expectation per rsp_valid pulse; between pulses the fields must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.due);
          check("rsp_hit", bus.rsp_hit, e.hit);
          check("rsp_addr", bus.rsp_addr, e.addr);
          check("rsp_count", bus.rsp_count, e.cnt);
          last = e;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("rsp_missing", 0, 1);
          void'(sb.pop_front());
        end
        check("hold_hit", bus.rsp_hit, last.hit);
        check("hold_addr", bus.rsp_addr, last.addr);
        check("hold_count", bus.rsp_count, last.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    do_reset();

    // Empty CAM misses
    lookup(16'h0000);
    idle(1);

    // Init walk, then hit on an index value and miss beyond it
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, '0);
    idle(DEPTH);
    lookup(16'd5);
    lookup(16'd9);

    // Duplicates: entries 2, 3, 6 all hold 3
    write(2, 16'h0003);
    write(6, 16'h0003);
    lookup(16'h0003);

    // Invalidate, then same-cycle write and lookup sees pre-write contents
    step(1'b0, 1'b1, 1'b1, 2, '0, 1'b0, '0);
    lookup(16'h0003);
    step(1'b0, 1'b1, 1'b0, 3, 16'hBEEF, 1'b1, 16'h0003);
    lookup(16'h0003);
    lookup(16'hBEEF);

    // Requests during the walk are dropped; init with same-cycle lookup and write
    step(1'b1, 1'b1, 1'b0, 4, 16'h0042, 1'b1, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 1, 16'h0055, 1'b1, 16'h0001);
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 16'h0002);
    idle(DEPTH - 2);
    for (int k = 0; k < DEPTH; k++) lookup(DATA_W'(k));
    lookup(16'h0042);
    idle(1);

    // Reset in the middle of the walk
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, '0);
    idle(4);
    do_reset();
    lookup(16'd1);
    lookup(16'd0);
    idle(1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 3,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, DEPTH - 1)),
           DATA_W'($urandom_range(0, 11)),
           $urandom_range(0, 1) == 1,
           DATA_W'($urandom_range(0, 11)));
    end
    idle(DEPTH + 2);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
